// File: rtl/pp_pipeline_accel_fifo2axis.sv
// pp_pipeline_accel_fifo2axis
// Drains a first-word-fall-through FIFO into an AXI4-Stream master, one
// frame of rows x cols beats per ap_start. TLAST marks the end of every row.
// Optional build macro PP_FIFO2AXIS_TUSER_EN: drives TUSER high on the first
// beat of each frame (row 0, column 0); without it TUSER is tied low.
module pp_pipeline_accel_fifo2axis #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    output logic                  ap_busy,
    output logic                  ap_done,
    input  logic                  if_empty_n,
    output logic                  if_read,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

    state_t               state;
    logic [DIM_WIDTH-1:0] rows_l;
    logic [DIM_WIDTH-1:0] cols_l;
    logic [DIM_WIDTH-1:0] row_cnt;
    logic [DIM_WIDTH-1:0] col_cnt;
    logic                 slot_free;
    logic                 col_end;
    logic                 row_end;
    logic                 pop;

    // The output register can take a new word when it is empty or being drained.
    assign slot_free = ~m_axis_tvalid | m_axis_tready;
    assign col_end   = (col_cnt == cols_l - DIM_ONE);
    assign row_end   = (row_cnt == rows_l - DIM_ONE);
    // Reset gating keeps the FIFO untouched during the reset cycle.
    assign pop       = ~reset & (state == RUN) & if_empty_n & slot_free;
    assign if_read   = pop;

    // Frame control: state, latched dimensions, position counters, busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rows_l  <= '0;
            cols_l  <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            ap_busy <= 1'b0;
            ap_done <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        rows_l  <= rows;
                        cols_l  <= cols;
                        row_cnt <= '0;
                        col_cnt <= '0;
                        if (rows == '0 || cols == '0) begin
                            // Empty frame: complete immediately without popping.
                            ap_done <= 1'b1;
                        end else begin
                            state   <= RUN;
                            ap_busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop) begin
                        if (col_end) begin
                            col_cnt <= '0;
                            if (row_end) begin
                                row_cnt <= '0;
                                state   <= FLUSH;
                            end else begin
                                row_cnt <= row_cnt + DIM_ONE;
                            end
                        end else begin
                            col_cnt <= col_cnt + DIM_ONE;
                        end
                    end
                end
                FLUSH: begin
                    // Only the final word can be held here; its handshake ends the frame.
                    if (m_axis_tvalid && m_axis_tready) begin
                        state   <= IDLE;
                        ap_busy <= 1'b0;
                        ap_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output register: capture on pop, drop valid when drained with no refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (pop) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= if_dout;
            m_axis_tlast  <= col_end;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef PP_FIFO2AXIS_TUSER_EN
    logic tuser_q;

    // Start-of-frame marker loads alongside the data word.
    always_ff @(posedge clk) begin
        if (reset) begin
            tuser_q <= 1'b0;
        end else if (pop) begin
            tuser_q <= (row_cnt == '0) && (col_cnt == '0);
        end
    end

    assign m_axis_tuser = tuser_q;
`else
    assign m_axis_tuser = 1'b0;
`endif

endmodule

// File: doc/pp_pipeline_accel_fifo2axis.md
PP_PIPELINE_ACCEL_FIFO2AXIS -- requirements
Module: pp_pipeline_accel_fifo2axis

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the FIFO word and stream data.
REQ-002 SHALL have parameter DIM_WIDTH, default 16, width of the row and column counts.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ap_start, input, 1, one-cycle frame start request.
REQ-006 SHALL have ports rows and cols, input, DIM_WIDTH each, frame height and width in beats.
REQ-007 SHALL have ports ap_busy (output, 1, frame in progress) and ap_done (output, 1, one-cycle frame-complete pulse).
REQ-008 SHALL have ports if_empty_n (input, 1), if_read (output, 1) and if_dout (input, DATA_WIDTH), the FIFO read side; if_dout is valid in the same cycle as if_empty_n (first-word fall-through).
REQ-009 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1) and m_axis_tuser (output, 1), an AXI4-Stream master.

Function
REQ-010 SHALL implement states IDLE, RUN and FLUSH.
- IDLE -> RUN on ap_start.
- RUN -> FLUSH when the final frame word is popped.
- FLUSH -> IDLE when the final beat is accepted.
REQ-011 SHALL latch rows and cols on the ap_start cycle; input changes during a frame have no effect.
REQ-012 SHALL ignore ap_start outside IDLE.
REQ-013 SHALL, on ap_start with rows==0 or cols==0, go straight to IDLE, pulse ap_done the next cycle and pop nothing.
REQ-014 SHALL hold a single output register (tdata, tlast, tuser, tvalid) that loads when the register is empty or m_axis_tready=1.
REQ-015 SHALL assert if_read combinationally = (state==RUN) & if_empty_n & (~m_axis_tvalid | m_axis_tready), and capture if_dout into the register in that cycle.
REQ-016 SHALL sustain one beat per cycle while the FIFO is non-empty and m_axis_tready=1.
REQ-017 SHALL clear m_axis_tvalid on a cycle with tready=1 and no pop; m_axis_tdata, tlast and tuser SHALL stay stable while tvalid=1 and tready=0.
REQ-018 SHALL keep column counter 0..cols-1 and row counter 0..rows-1, both advanced per pop.
- Column wraps to 0 at cols-1, and the row increments on that wrap.
- Comparisons are unsigned DIM_WIDTH.
REQ-019 SHALL set tlast on the word popped at column cols-1 (end of every row).
REQ-020 SHALL treat the pop at row rows-1, column cols-1 as the final word and deassert if_read from the next cycle.
REQ-021 SHALL assert ap_busy from the cycle after ap_start until the cycle ap_done is pulsed.
REQ-022 SHALL pulse ap_done for exactly one cycle, in the cycle after the final beat handshake (tvalid & tready with final word).
REQ-023 SHALL add latency from FIFO pop to tvalid of exactly one cycle.

Reset
REQ-024 SHALL, on reset, set state=IDLE, counters=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, ap_busy=0 and ap_done=0.
REQ-025 SHALL abort any frame on reset mid-operation, discarding the held beat; if_read SHALL be 0 during the reset cycle.

Configuration
REQ-026 SHALL, with macro PP_FIFO2AXIS_TUSER_EN defined, set m_axis_tuser=1 on the first beat of each frame (row 0, column 0) and 0 otherwise.
REQ-027 SHALL, without PP_FIFO2AXIS_TUSER_EN, hold m_axis_tuser at constant 0 and omit its logic.

Verification
REQ-028 SHALL cover full-rate frame: rows=2, cols=4, FIFO preloaded with 8 words, tready=1.
- 8 consecutive beats.
- tlast on beats 4 and 8.
- ap_done one cycle after beat 8.
REQ-029 SHALL cover backpressure: tready=0 for 5 cycles mid-frame.
- tdata, tlast and tuser stable; if_read=0 throughout.
- No beat lost or duplicated.
REQ-030 SHALL cover starved FIFO: if_empty_n toggles 1/0 every cycle.
- tvalid gaps match.
- Data order preserved; row/column counters correct.
REQ-031 SHALL cover zero dimension: ap_start with rows=0, cols=5.
- ap_done next cycle; no if_read; no tvalid.
REQ-032 SHALL cover reset mid-frame after 3 of 8 beats, then new ap_start rows=1, cols=2.
- Outputs return to reset values.
- New frame emits 2 beats, tlast on the 2nd.
REQ-033 SHALL cover TUSER build: with PP_FIFO2AXIS_TUSER_EN, tuser=1 only on the first beat of each of two back-to-back frames; without it, tuser=0 always.
